// File: rtl/stream_converge_arbiter.sv
// -----------------------------------------------------------------------------
// stream_converge_arbiter
//
// Merges input-port credit (freespace) update packets and output-port data
// packets onto one leaf stream, one packet per clock. Credit packets normally
// win; a starvation guard forces a data grant after STARVE_LIMIT consecutive
// credit sends while data is waiting. Data arbitration is round-robin
// (arb_mode = 0) or fixed lowest-index priority with a burst limit
// (arb_mode = 1). While resend is high the stream output is held and no grant
// is issued.
//
// Ports:
//   clk                       BFT clock
//   reset                     synchronous, active-high
//   resend                    hold stream_out, no grants, state frozen
//   arb_mode                  0 = round-robin, 1 = fixed priority + burst limit
//   freespace_update[i]       1-cycle request to send port i's credit packet
//   packet_from_input_ports   credit packet per input port (slice i = port i)
//   packet_from_output_ports  FWFT head packet per output FIFO (slice j)
//   empty[j]                  output FIFO j empty
//   rd_en_sel[j]              combinational one-hot pop strobe to FIFO j
//   stream_out                registered merged packet (MSB = valid)
//   starve_event              registered pulse when the guard forced data
// -----------------------------------------------------------------------------
module stream_converge_arbiter #(
    parameter int PACKET_BITS   = 97,
    parameter int NUM_IN_PORTS  = 7,
    parameter int NUM_OUT_PORTS = 7,
    parameter int MAX_BURST     = 4,
    parameter int STARVE_LIMIT  = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   resend,
    input  logic                                   arb_mode,
    input  logic [NUM_IN_PORTS-1:0]                freespace_update,
    input  logic [PACKET_BITS*NUM_IN_PORTS-1:0]    packet_from_input_ports,
    input  logic [PACKET_BITS*NUM_OUT_PORTS-1:0]   packet_from_output_ports,
    input  logic [NUM_OUT_PORTS-1:0]               empty,
    output logic [NUM_OUT_PORTS-1:0]               rd_en_sel,
    output logic [PACKET_BITS-1:0]                 stream_out,
    output logic                                   starve_event
);

    localparam int IN_W     = (NUM_IN_PORTS  > 1) ? $clog2(NUM_IN_PORTS)  : 1;
    localparam int OUT_W    = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
    localparam int BURST_W  = $clog2(MAX_BURST + 1);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int MAX_N    = (NUM_IN_PORTS > NUM_OUT_PORTS) ? NUM_IN_PORTS : NUM_OUT_PORTS;

    // First set request at or after ptr, wrapping at n.
    function automatic int rr_pick(input logic [MAX_N-1:0] req, input int n, input int ptr);
        int  res;
        int  idx;
        logic found;
        res   = 0;
        found = 1'b0;
        for (int k = 0; k < MAX_N; k++) begin
            if (!found && (k < n)) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (req[idx]) begin
                    res   = idx;
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

    // Lowest set request index.
    function automatic int lowest_set(input logic [MAX_N-1:0] req);
        int res;
        res = 0;
        for (int k = MAX_N - 1; k >= 0; k--) begin
            if (req[k]) res = k;
        end
        return res;
    endfunction

    logic [NUM_IN_PORTS-1:0] pending_q,      pending_d;
    logic [IN_W-1:0]         in_ptr_q,       in_ptr_d;
    logic [OUT_W-1:0]        out_ptr_q,      out_ptr_d;
    logic [OUT_W-1:0]        last_port_q,    last_port_d;
    logic [BURST_W-1:0]      burst_cnt_q,    burst_cnt_d;
    logic [STARVE_W-1:0]     starve_cnt_q,   starve_cnt_d;
    logic [PACKET_BITS-1:0]  stream_out_q,   stream_out_d;
    logic                    starve_event_q, starve_event_d;

    logic                     active;
    logic                     any_pending;
    logic                     any_data;
    logic                     force_data;
    logic                     credit_go;
    logic                     data_go;
    logic [NUM_OUT_PORTS-1:0] avail;
    logic [MAX_N-1:0]         avail_w;
    logic [MAX_N-1:0]         masked_w;
    logic [NUM_IN_PORTS-1:0]  clear_vec;
    logic [PACKET_BITS-1:0]   in_pkt;
    logic [PACKET_BITS-1:0]   out_pkt;
    int                       in_grant;
    int                       out_grant;
    int                       low_idx;

    // ---- decision stage: class select, port select, next state ----
    always_comb begin
        avail       = ~empty;
        avail_w     = MAX_N'(avail);
        any_pending = |pending_q;
        any_data    = |avail;
        active      = !reset && !resend;
        force_data  = any_data && (starve_cnt_q == STARVE_W'(STARVE_LIMIT));
        credit_go   = active && any_pending && !force_data;
        data_go     = active && any_data && (!any_pending || force_data);

        in_grant = rr_pick(MAX_N'(pending_q), NUM_IN_PORTS, int'(in_ptr_q));

        // Fixed priority: the lowest port loses one decision once it has used
        // up its burst and someone else is waiting.
        low_idx  = lowest_set(avail_w);
        masked_w = avail_w & ~(MAX_N'(1) << low_idx);
        if ((low_idx == int'(last_port_q)) && (burst_cnt_q == BURST_W'(MAX_BURST)) &&
            (|masked_w)) begin
            low_idx = lowest_set(masked_w);
        end

        if (arb_mode) out_grant = low_idx;
        else          out_grant = rr_pick(avail_w, NUM_OUT_PORTS, int'(out_ptr_q));

        in_pkt = '0;
        for (int i = 0; i < NUM_IN_PORTS; i++) begin
            if (i == in_grant) in_pkt = packet_from_input_ports[i*PACKET_BITS +: PACKET_BITS];
        end
        out_pkt = '0;
        for (int j = 0; j < NUM_OUT_PORTS; j++) begin
            if (j == out_grant) out_pkt = packet_from_output_ports[j*PACKET_BITS +: PACKET_BITS];
        end

        rd_en_sel = data_go ? (NUM_OUT_PORTS'(1) << out_grant) : '0;

        // A new request in the same cycle as the send keeps the bit set.
        clear_vec = credit_go ? (NUM_IN_PORTS'(1) << in_grant) : '0;
        pending_d = (pending_q & ~clear_vec) | freespace_update;

        in_ptr_d = in_ptr_q;
        if (credit_go) begin
            in_ptr_d = (in_grant + 1 >= NUM_IN_PORTS) ? '0 : IN_W'(in_grant + 1);
        end

        out_ptr_d   = out_ptr_q;
        last_port_d = last_port_q;
        burst_cnt_d = burst_cnt_q;
        if (data_go) begin
            if (!arb_mode) begin
                out_ptr_d = (out_grant + 1 >= NUM_OUT_PORTS) ? '0 : OUT_W'(out_grant + 1);
            end
            last_port_d = OUT_W'(out_grant);
            if ((out_grant == int'(last_port_q)) && (burst_cnt_q != '0)) begin
                if (burst_cnt_q != BURST_W'(MAX_BURST)) burst_cnt_d = burst_cnt_q + BURST_W'(1);
            end else begin
                burst_cnt_d = BURST_W'(1);
            end
        end

        starve_cnt_d = starve_cnt_q;
        if (active) begin
            if (data_go || !any_data) begin
                starve_cnt_d = '0;
            end else if (credit_go && (starve_cnt_q != STARVE_W'(STARVE_LIMIT))) begin
                starve_cnt_d = starve_cnt_q + STARVE_W'(1);
            end
        end

        if (resend)         stream_out_d = stream_out_q;
        else if (credit_go) stream_out_d = in_pkt;
        else if (data_go)   stream_out_d = out_pkt;
        else                stream_out_d = '0;

        starve_event_d = active && force_data;
    end

    // ---- output register stage ----
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q      <= '0;
            in_ptr_q       <= '0;
            out_ptr_q      <= '0;
            last_port_q    <= '0;
            burst_cnt_q    <= '0;
            starve_cnt_q   <= '0;
            stream_out_q   <= '0;
            starve_event_q <= 1'b0;
        end else begin
            pending_q      <= pending_d;
            in_ptr_q       <= in_ptr_d;
            out_ptr_q      <= out_ptr_d;
            last_port_q    <= last_port_d;
            burst_cnt_q    <= burst_cnt_d;
            starve_cnt_q   <= starve_cnt_d;
            stream_out_q   <= stream_out_d;
            starve_event_q <= starve_event_d;
        end
    end

    assign stream_out   = stream_out_q;
    assign starve_event = starve_event_q;

endmodule

// File: tb/tb_stream_converge_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stream_converge_arbiter
//
// Directed bench for stream_converge_arbiter with default parameters. Each
// table row is one clock: inputs are applied after the rising edge, rd_en_sel
// is checked on the falling edge, and stream_out / starve_event are checked
// just after the next rising edge. A hand-written loop covers the
// credit-starvation sequence.
// -----------------------------------------------------------------------------
module tb_stream_converge_arbiter;

    localparam int PB = 97;
    localparam int NI = 7;
    localparam int NO = 7;

    logic              clk = 1'b0;
    logic              reset;
    logic              resend;
    logic              arb_mode;
    logic [NI-1:0]     freespace_update;
    logic [PB*NI-1:0]  packet_from_input_ports;
    logic [PB*NO-1:0]  packet_from_output_ports;
    logic [NO-1:0]     empty;
    logic [NO-1:0]     rd_en_sel;
    logic [PB-1:0]     stream_out;
    logic              starve_event;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stream_converge_arbiter #(
        .PACKET_BITS  (PB),
        .NUM_IN_PORTS (NI),
        .NUM_OUT_PORTS(NO),
        .MAX_BURST    (4),
        .STARVE_LIMIT (16)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .resend                  (resend),
        .arb_mode                (arb_mode),
        .freespace_update        (freespace_update),
        .packet_from_input_ports (packet_from_input_ports),
        .packet_from_output_ports(packet_from_output_ports),
        .empty                   (empty),
        .rd_en_sel               (rd_en_sel),
        .stream_out              (stream_out),
        .starve_event            (starve_event)
    );

    function automatic logic [PB-1:0] cpk(input int i);
        logic [PB-1:0] p;
        p          = '0;
        p[PB-1]    = 1'b1;
        p[95:64]   = 32'hC0DE_0000 + i;
        p[31:0]    = 32'h1111_0000 + i;
        return p;
    endfunction

    function automatic logic [PB-1:0] dpk(input int j);
        logic [PB-1:0] p;
        p          = '0;
        p[PB-1]    = 1'b1;
        p[95:64]   = 32'hDA7A_0000 + j;
        p[31:0]    = 32'h2222_0000 + j;
        return p;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic          rst;
        logic          rsd;
        logic          mode;
        logic [NI-1:0] fu;
        logic [NO-1:0] emp;
        logic [NO-1:0] exp_rd;
        logic [PB-1:0] exp_out;
        logic          exp_st;
    } vec_t;

    vec_t tbl[64];
    int   n_vec = 0;

    task automatic add(input logic rst, input logic rsd, input logic mode,
                       input logic [NI-1:0] fu, input logic [NO-1:0] emp,
                       input logic [NO-1:0] erd, input logic [PB-1:0] eo, input logic est);
        tbl[n_vec] = '{rst, rsd, mode, fu, emp, erd, eo, est};
        n_vec++;
    endtask

    // One clock: drive, check combinational strobe mid-cycle, check registers after edge.
    task automatic run_cycle(input string nm, input logic rst, input logic rsd, input logic mode,
                             input logic [NI-1:0] fu, input logic [NO-1:0] emp,
                             input logic [NO-1:0] erd, input logic [PB-1:0] eo, input logic est);
        reset            = rst;
        resend           = rsd;
        arb_mode         = mode;
        freespace_update = fu;
        empty            = emp;
        @(negedge clk);
        chk({nm, " rd_en_sel"}, 128'(rd_en_sel), 128'(erd));
        chk({nm, " rd_on_empty"}, 128'(rd_en_sel & empty), 128'(0));
        @(posedge clk);
        #1;
        chk({nm, " stream_out"}, 128'(stream_out), 128'(eo));
        chk({nm, " starve_event"}, 128'(starve_event), 128'(est));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NO-1:0] E;
        logic [PB-1:0] Z;
        E = '1;
        Z = '0;

        for (int i = 0; i < NI; i++) packet_from_input_ports[i*PB +: PB] = cpk(i);
        for (int j = 0; j < NO; j++) packet_from_output_ports[j*PB +: PB] = dpk(j);

        // rst rsd mode fu          empty        rd_en   stream_out st
        add(1, 0, 0, 7'b0000000, E,            7'h00, Z,      0); // 0 reset
        add(0, 0, 0, 7'b0000000, E,            7'h00, Z,      0);
        add(0, 0, 0, 7'b0000000, E,            7'h00, Z,      0);
        add(0, 0, 0, 7'b0000101, E,            7'h00, Z,      0); // 3 requests latch
        add(0, 0, 0, 7'b0000000, E,            7'h00, cpk(0), 0);
        add(0, 0, 0, 7'b0000000, E,            7'h00, cpk(2), 0);
        add(0, 0, 0, 7'b0000000, E,            7'h00, Z,      0);
        add(0, 0, 0, 7'b0000000, 7'b1111010,   7'h01, dpk(0), 0); // 7 RR data
        add(0, 0, 0, 7'b0000000, 7'b1111010,   7'h04, dpk(2), 0);
        add(0, 0, 0, 7'b0000000, 7'b1111010,   7'h01, dpk(0), 0);
        add(0, 0, 0, 7'b0000000, 7'b1111010,   7'h04, dpk(2), 0);
        for (int k = 0; k < 2; k++) begin                          // 11 fixed + burst
            for (int r = 0; r < 4; r++) add(0, 0, 1, 7'b0, 7'b1111100, 7'h01, dpk(0), 0);
            add(0, 0, 1, 7'b0, 7'b1111100, 7'h02, dpk(1), 0);
        end
        for (int r = 0; r < 5; r++) add(0, 0, 1, 7'b0, 7'b1111110, 7'h01, dpk(0), 0); // 21 lone port
        add(0, 0, 0, 7'b0000000, 7'b1111100,   7'h01, dpk(0), 0); // 26 RR ptr wraps
        for (int r = 0; r < 3; r++) add(0, 1, 0, 7'b0, 7'b1111100, 7'h00, dpk(0), 0); // 27 resend
        add(0, 0, 0, 7'b0000000, 7'b1111100,   7'h02, dpk(1), 0); // 30 resumes at port 1
        add(0, 1, 0, 7'b0010000, E,            7'h00, dpk(1), 0); // 31 set during resend
        add(0, 0, 0, 7'b0000000, E,            7'h00, cpk(4), 0);
        add(0, 0, 0, 7'b0000000, E,            7'h00, Z,      0);
        add(0, 0, 0, 7'b0000010, E,            7'h00, Z,      0); // 34
        add(0, 0, 0, 7'b0000000, 7'b1111110,   7'h00, cpk(1), 0); // credit beats data
        add(0, 0, 0, 7'b0000000, 7'b1111110,   7'h01, dpk(0), 0);
        add(0, 0, 0, 7'b0000001, E,            7'h00, Z,      0); // 37
        add(0, 0, 0, 7'b0000001, E,            7'h00, cpk(0), 0); // set wins over clear
        add(0, 0, 0, 7'b0000000, E,            7'h00, cpk(0), 0);
        add(0, 0, 0, 7'b0000000, E,            7'h00, Z,      0);
        add(1, 0, 0, 7'b0000001, 7'b1111110,   7'h00, Z,      0); // 41 mid-stream reset
        add(0, 0, 0, 7'b0000000, E,            7'h00, Z,      0);
        add(0, 0, 0, 7'b0000000, 7'b1111010,   7'h01, dpk(0), 0); // pointer reset to 0
        add(0, 0, 0, 7'b0000000, 7'b1111010,   7'h04, dpk(2), 0);

        reset            = 1'b1;
        resend           = 1'b0;
        arb_mode         = 1'b0;
        freespace_update = '0;
        empty            = '1;

        for (int v = 0; v < n_vec; v++) begin
            run_cycle($sformatf("row%0d", v), tbl[v].rst, tbl[v].rsd, tbl[v].mode,
                      tbl[v].fu, tbl[v].emp, tbl[v].exp_rd, tbl[v].exp_out, tbl[v].exp_st);
        end

        // Starvation: port 3 requests for 30 cycles, output port 5 waiting.
        for (int c = 0; c < 33; c++) begin
            logic [NI-1:0] fu;
            logic [NO-1:0] emp;
            logic [NO-1:0] erd;
            logic [PB-1:0] eo;
            fu  = (c < 30) ? 7'b0001000 : 7'b0000000;
            emp = (c == 0 || c == 32) ? E : 7'b1011111;
            erd = (c == 17 || c == 31) ? 7'h20 : 7'h00;
            if (c == 0 || c == 32)       eo = Z;
            else if (c == 17 || c == 31) eo = dpk(5);
            else                         eo = cpk(3);
            run_cycle($sformatf("starve%0d", c), 1'b0, 1'b0, 1'b0, fu, emp, erd, eo, (c == 17));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_converge_arbiter.md
Name: stream_converge_arbiter

Overview:
- Parametrised successor to the leaf-interface converge controller. Merges input-port freespace (credit) update packets and output-port data packets onto the single leaf stream_out, one packet per clk cycle.
- Adds a selectable arbitration mode: round-robin, or fixed priority with a burst limit.
- Adds a credit-starvation guard and resend hold.
- Sits between Input/Output port clusters and the BFT leaf, in the clk(_bft) domain.

Parameters:
PACKET_BITS, 97, packet width; bit PACKET_BITS-1 is the valid bit
NUM_IN_PORTS, 7, number of input ports (freespace update sources)
NUM_OUT_PORTS, 7, number of output ports (data FIFOs)
MAX_BURST, 4, max consecutive grants to one output port in fixed-priority mode while another is non-empty
STARVE_LIMIT, 16, max consecutive credit-packet cycles while any output port is non-empty

Ports:
clk  in  1  single clock (BFT clock)
reset  in  1  synchronous, active-high
resend  in  1  hold current stream_out; no grants
arb_mode  in  1  0 = round-robin, 1 = fixed priority (lowest index) with MAX_BURST limit; sampled every cycle
freespace_update  in  NUM_IN_PORTS  per-port 1-cycle request to send a credit packet
packet_from_input_ports  in  PACKET_BITS*NUM_IN_PORTS  credit packet per input port, slice i = port i
packet_from_output_ports  in  PACKET_BITS*NUM_OUT_PORTS  FWFT head packet per output FIFO
empty  in  NUM_OUT_PORTS  output FIFO empty flags
rd_en_sel  out  NUM_OUT_PORTS  one-hot pop strobe to output FIFOs (combinational)
stream_out  out  PACKET_BITS  registered merged packet stream
starve_event  out  1  registered 1-cycle pulse when the starvation guard forces a data grant

Behaviour:
- Reset (sync, active-high):
  - stream_out = 0, starve_event = 0.
  - pending[] = 0, both RR pointers = 0, burst counter = 0, starve counter = 0.
  - rd_en_sel forced 0 while reset is high.
- pending[i] latches on freespace_update[i] and clears when port i's credit packet is sent. If set and clear coincide, set wins: pending stays 1 and the packet is sent again later.
- Decision, every cycle resend = 0:
  - Class selection: credit class wins if any pending bit is set, unless starve_cnt == STARVE_LIMIT and some empty[j] == 0. In that case the data class is forced and starve_event pulses the next cycle.
  - Credit class: round-robin among pending[] from the in_ptr. in_ptr <= granted+1, wrapping at NUM_IN_PORTS. Next cycle, stream_out <= slice i of packet_from_input_ports.
  - Data class, arb_mode = 0: round-robin among ~empty from out_ptr. out_ptr <= granted+1, wrapping.
  - Data class, arb_mode = 1: lowest non-empty index wins. If that index equals the last granted port, burst_cnt == MAX_BURST, and another port is non-empty, it is masked for this decision.
  - burst_cnt resets to 1 on a port change and saturates at MAX_BURST.
  - Data grant: rd_en_sel[j] = 1 in the decision cycle. Next cycle, stream_out <= slice j.
  - Nothing to send: stream_out <= 0 (valid bit 0); rd_en_sel = 0.
- starve_cnt:
  - Increments on a credit send while any output is non-empty, saturating at STARVE_LIMIT.
  - Clears on any data send, or when all outputs are empty.
- Latency: 1 cycle from grant to stream_out. Throughput: 1 packet/cycle.
- resend = 1:
  - stream_out holds its value; rd_en_sel = 0.
  - pending[], pointers and counters are frozen, except pending[] still sets on new freespace_update.
- arb_mode change takes effect on the next decision. Pointers and burst_cnt are retained.
- rd_en_sel is at most one-hot. It is never asserted for a port with empty = 1.
- Implementation budget: ~200 RTL lines.

Test Plan:
- Reset, then empty = all 1, no updates -> stream_out = 0 every cycle, rd_en_sel = 0.
- freespace_update = 7'b0000101 for one cycle, outputs empty -> stream_out carries port 0's credit packet, then port 2's, on consecutive cycles; then 0.
- arb_mode = 0, empty = 7'b1111010 (ports 0 and 2 non-empty) held -> rd_en_sel alternates 0x01, 0x04, 0x01...; stream_out follows one cycle later.
- arb_mode = 1, MAX_BURST = 4, ports 0 and 1 non-empty -> grants 0,0,0,0,1,0,0,0,0,1...
- freespace_update held high for 30 cycles on port 3, output port 5 non-empty -> 16 credit packets, then one port-5 data grant with starve_event pulsing, then credit packets resume.
- resend high for 3 cycles mid-stream with port 1 non-empty -> stream_out unchanged, rd_en_sel = 0; the first grant after resend drops goes to port 1.
